// File: rtl/jk_mod_counter_if.sv
// Command/status bundle for jk_mod_counter: master drives jk/up_dn/din,
// slave (the counter) returns q/qb/tc/wrap.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       jk;
    logic             up_dn;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;
    logic             wrap;

    modport master (
        output jk, up_dn, din,
        input  q, qb, tc, wrap
    );

    modport slave (
        input  jk, up_dn, din,
        output q, qb, tc, wrap
    );
endinterface

// File: rtl/jk_mod_counter.sv
// WIDTH-bit modulo-MODULUS counter driven by a 2-bit JK-style command.
// Define JK_MOD_COUNTER_SAT_EN to make counting saturate instead of wrap.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    jk_mod_counter_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("jk_mod_counter: WIDTH=%0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end

    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_LOAD  = 2'b10;
    localparam logic [1:0] CMD_COUNT = 2'b11;

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qb_q;
    logic             wrap_q, wrap_d;
    logic             at_end;

    // Wrap is decided by compare, so MODULUS == 2**WIDTH never relies on overflow.
    assign at_end = bus.up_dn ? (q_q == MAX_Q) : (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        case (bus.jk)
            CMD_HOLD:  q_d = q_q;
            CMD_CLEAR: q_d = '0;
            CMD_LOAD:  q_d = (bus.din > MAX_Q) ? MAX_Q : bus.din;
            CMD_COUNT: begin
                if (at_end) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                    q_d = q_q;
`else
                    q_d    = bus.up_dn ? '0 : MAX_Q;
                    wrap_d = 1'b1;
`endif
                end else begin
                    q_d = bus.up_dn ? q_q + ONE : q_q - ONE;
                end
            end
            // NOTE: an X/Z command matches no item, so the next state goes X
            // in simulation rather than quietly holding.
            default: begin
                q_d    = 'x;
                wrap_d = 1'bx;
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            qb_q   <= '1;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            qb_q   <= ~q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.qb   = qb_q;
    assign bus.wrap = wrap_q;
    assign bus.tc   = (bus.jk == CMD_COUNT) && at_end;

    a_qb_tracks_q: assert property (
        @(posedge clk) !$isunknown(bus.jk) |=> (qb_q == ~q_q)
    );

    a_wrap_only_at_end: assert property (
        @(posedge clk) !(!rst && bus.jk == CMD_COUNT && at_end) |=> !wrap_q
    );

endmodule
